// File: rtl/gcd_sweep_ctrl.sv
// Sweep controller for the GCD engine: walks every ordered operand pair in
// [MIN, MAX] x [MIN, MAX], issues one request per pair, and accumulates statistics.
module gcd_sweep_ctrl #(
  parameter int unsigned W       = 7,
  parameter int unsigned MIN     = 1,
  parameter int unsigned MAX     = 15,
  parameter int unsigned CW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          gcd_req,
  output logic [W-1:0]  gcd_a,
  output logic [W-1:0]  gcd_b,
  input  logic          gcd_done,
  input  logic [W-1:0]  gcd_result,
  output logic          busy,
  output logic          sweep_done,
  output logic          err,
  output logic [CW-1:0] pair_cnt,
  output logic [CW-1:0] coprime_cnt,
  output logic [W-1:0]  max_gcd
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]   OP_MIN  = W'(MIN);
  localparam logic [W-1:0]   OP_MAX  = W'(MAX);
  localparam logic [W-1:0]   RES_ONE = W'(1);
  localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RECORD, S_DONE, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   res_q, res_d, max_q, max_d;
  logic [CW-1:0]  pair_q, pair_d, cop_q, cop_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           req_q, req_d, busy_q, busy_d;
  logic           sdone_q, sdone_d, err_q, err_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= OP_MIN;
      b_q     <= OP_MIN;
      res_q   <= '0;
      max_q   <= '0;
      pair_q  <= '0;
      cop_q   <= '0;
      wd_q    <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      sdone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      max_q   <= max_d;
      pair_q  <= pair_d;
      cop_q   <= cop_d;
      wd_q    <= wd_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      sdone_q <= sdone_d;
      err_q   <= err_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    max_d   = max_q;
    pair_d  = pair_q;
    cop_d   = cop_q;
    wd_d    = wd_q;
    sdone_d = sdone_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          pair_d  = '0;
          cop_d   = '0;
          max_d   = '0;
          sdone_d = 1'b0;
          err_d   = 1'b0;
          a_d     = OP_MIN;
          b_d     = OP_MIN;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // wd_q == 0 marks the first WAIT cycle, where a stale level done is ignored
        if (gcd_done && (wd_q != '0)) begin
          res_d   = gcd_result;
          state_d = S_RECORD;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_RECORD: begin
        if (pair_q != CNT_MAX) pair_d = pair_q + CW'(1);
        if ((res_q == RES_ONE) && (cop_q != CNT_MAX)) cop_d = cop_q + CW'(1);
        if (res_q > max_q) max_d = res_q;
        if ((a_q == OP_MAX) && (b_q == OP_MAX)) begin
          sdone_d = 1'b1;
          state_d = S_DONE;
        end else begin
          if (b_q < OP_MAX) begin
            b_d = b_q + W'(1);
          end else begin
            b_d = OP_MIN;
            a_d = a_q + W'(1);
          end
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d  = (state_d == S_ISSUE);
    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_RECORD);
  end

  assign gcd_req     = req_q;
  assign gcd_a       = a_q;
  assign gcd_b       = b_q;
  assign busy        = busy_q;
  assign sweep_done  = sdone_q;
  assign err         = err_q;
  assign pair_cnt    = pair_q;
  assign coprime_cnt = cop_q;
  assign max_gcd     = max_q;

endmodule

// File: tb/tb_gcd_sweep_ctrl.sv
// Bench for gcd_sweep_ctrl: a behavioural GCD engine feeds two DUT configurations;
// sweep results are checked against statistics derived from the observed request log.
module tb_gcd_sweep_ctrl;

  localparam int unsigned W    = 7;
  localparam int unsigned MAXA = 15;
  localparam int unsigned CWA  = 16;
  localparam int unsigned TOA  = 8;
  localparam int unsigned MAXB = 3;
  localparam int unsigned CWB  = 3;
  localparam int unsigned TOB  = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic           req0, req1, busy0, busy1, sd0, sd1, err0, err1;
  logic [W-1:0]   ga0, gb0, ga1, gb1, mx0, mx1;
  logic [CWA-1:0] pc0, cc0;
  logic [CWB-1:0] pc1, cc1;
  logic           done;
  logic [W-1:0]   res;

  gcd_sweep_ctrl #(.W(W), .MIN(1), .MAX(MAXA), .CW(CWA), .TIMEOUT(TOA)) u_dut_a (
    .clk(clk), .rst(rst), .start(start0), .gcd_req(req0), .gcd_a(ga0), .gcd_b(gb0),
    .gcd_done(done), .gcd_result(res), .busy(busy0), .sweep_done(sd0), .err(err0),
    .pair_cnt(pc0), .coprime_cnt(cc0), .max_gcd(mx0));

  gcd_sweep_ctrl #(.W(W), .MIN(1), .MAX(MAXB), .CW(CWB), .TIMEOUT(TOB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start1), .gcd_req(req1), .gcd_a(ga1), .gcd_b(gb1),
    .gcd_done(done), .gcd_result(res), .busy(busy1), .sweep_done(sd1), .err(err1),
    .pair_cnt(pc1), .coprime_cnt(cc1), .max_gcd(mx1));

  int tests = 0, fails = 0;
  int sel = 0;
  int mode = 0, lat_lo = 3, lat_hi = 3, rnd = 0, stall = 0, sa = 0, sb = 0;

  logic act_req, act_busy, act_sd, act_err;
  logic [W-1:0] act_a, act_b;
  int act_pc, act_cc, act_mx;

  always_comb begin
    if (sel == 0) begin
      act_req = req0; act_busy = busy0; act_sd = sd0; act_err = err0;
      act_a = ga0; act_b = gb0; act_pc = int'(pc0); act_cc = int'(cc0); act_mx = int'(mx0);
    end else begin
      act_req = req1; act_busy = busy1; act_sd = sd1; act_err = err1;
      act_a = ga1; act_b = gb1; act_pc = int'(pc1); act_cc = int'(cc1); act_mx = int'(mx1);
    end
  end

  typedef struct {int a; int b; int r; int lat; int cyc;} rec_t;
  rec_t q[$];
  rec_t nr;
  int cyc = 0, stab_err = 0, cnt = 0, cur_lat = 0;
  bit pend = 1'b0;
  logic [W-1:0] cur_a = '0, cur_b = '0, cur_res = '0;

  function automatic int gcd(input int x, input int y);
    int t;
    while (y != 0) begin t = y; y = x % y; x = t; end
    return x;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine: latches operands on req, answers after a drawn latency
  always @(negedge clk) begin
    if (rst) begin
      pend <= 1'b0;
    end else if (act_req) begin
      nr.a   = int'(act_a);
      nr.b   = int'(act_b);
      nr.lat = (mode == 2) ? 2 : int'($urandom_range(lat_hi, lat_lo));
      nr.r   = (rnd != 0) ? int'($urandom_range(127, 0)) : gcd(nr.a, nr.b);
      nr.cyc = cyc;
      q.push_back(nr);
      pend    <= 1'b1;
      cnt     <= 0;
      cur_lat <= nr.lat;
      cur_a   <= act_a;
      cur_b   <= act_b;
      cur_res <= W'(nr.r);
    end else if (pend) begin
      cnt <= cnt + 1;
      if (act_busy && ((act_a != cur_a) || (act_b != cur_b))) stab_err++;
    end
  end

  always_comb begin
    done = 1'b0;
    if (mode == 2) done = 1'b1;
    else if (pend && !((stall != 0) && (cur_a == W'(sa)) && (cur_b == W'(sb))))
      done = (mode == 1) ? (cnt >= cur_lat) : (cnt == cur_lat);
    res = cur_res;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"}, int'(req0) + int'(req1), 0);
    chk({tag, "_busy"}, int'(busy0) + int'(busy1), 0);
    chk({tag, "_flags"}, int'(sd0) + int'(sd1) + int'(err0) + int'(err1), 0);
    chk({tag, "_cnts"}, int'(pc0) + int'(cc0) + int'(pc1) + int'(cc1), 0);
    chk({tag, "_max"}, int'(mx0) + int'(mx1), 0);
    chk({tag, "_ops"}, int'(ga0) * 1000 + int'(gb0) * 100 + int'(ga1) * 10 + int'(gb1), 1111);
  endtask

  typedef struct {
    int sel; int mode; int lat_lo; int lat_hi; int rnd; int stall; int sa; int sb; int spam;
    int ex_pairs; int ex_copr; int ex_max;
  } vec_t;
  vec_t tbl[9];

  task automatic run_vec(input vec_t v, input string tag);
    int n, sat, to, exp_nreq, compl, pairs, cop, mx, bexp, bcnt, guard, bad, k;
    sel = v.sel; mode = v.mode; lat_lo = v.lat_lo; lat_hi = v.lat_hi;
    rnd = v.rnd; stall = v.stall; sa = v.sa; sb = v.sb;
    q.delete();
    stab_err = 0;
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    bcnt = 0; guard = 0;
    while (act_busy && guard < 20000) begin
      bcnt++;
      set_start((v.spam != 0) && ($urandom_range(15, 0) == 0));
      @(negedge clk);
      guard++;
    end
    set_start(1'b0);
    chk({tag, "_finish"}, int'(guard < 20000), 1);

    n   = (v.sel == 0) ? int'(MAXA) : int'(MAXB);
    sat = (v.sel == 0) ? (1 << CWA) - 1 : (1 << CWB) - 1;
    to  = (v.sel == 0) ? int'(TOA) : int'(TOB);
    exp_nreq = (v.stall != 0) ? (v.sa - 1) * n + v.sb : n * n;
    compl    = (v.stall != 0) ? exp_nreq - 1 : exp_nreq;
    chk({tag, "_nreq"}, q.size(), exp_nreq);

    bad = 0;
    for (k = 0; k < q.size(); k++)
      if (q[k].a != k / n + 1 || q[k].b != k % n + 1) bad++;
    chk({tag, "_order"}, bad, 0);

    bad = 0;
    for (k = 1; k < q.size(); k++)
      if (q[k].cyc - q[k-1].cyc != q[k-1].lat + 2) bad++;
    chk({tag, "_spacing"}, bad, 0);
    chk({tag, "_stable"}, stab_err, 0);

    pairs = 0; cop = 0; mx = 0; bexp = (v.stall != 0) ? 1 + to : 0;
    for (k = 0; k < compl && k < q.size(); k++) begin
      pairs++;
      if (q[k].r == 1) cop++;
      if (q[k].r > mx) mx = q[k].r;
      bexp += q[k].lat + 2;
    end
    chk({tag, "_busy_cycles"}, bcnt, bexp);
    chk({tag, "_pair_cnt"}, act_pc, (pairs > sat) ? sat : pairs);
    chk({tag, "_coprime_cnt"}, act_cc, (cop > sat) ? sat : cop);
    chk({tag, "_max_gcd"}, act_mx, mx);
    chk({tag, "_sweep_done"}, int'(act_sd), (v.stall != 0) ? 0 : 1);
    chk({tag, "_err"}, int'(act_err), (v.stall != 0) ? 1 : 0);
    chk({tag, "_busy"}, int'(act_busy), 0);
    if (v.ex_pairs >= 0) begin
      chk({tag, "_tbl_pairs"}, act_pc, v.ex_pairs);
      chk({tag, "_tbl_copr"}, act_cc, v.ex_copr);
      chk({tag, "_tbl_max"}, act_mx, v.ex_max);
    end
  endtask

  initial begin
    int guard, reqs;
    //          sel mode lo hi rnd stl sa sb spam pairs copr max
    tbl[0] = '{0, 0, 3, 3, 0, 0, 0, 0, 0, 225, 143, 15};
    tbl[1] = '{0, 2, 2, 2, 0, 0, 0, 0, 0, 225, 143, 15};
    tbl[2] = '{0, 0, 3, 3, 0, 1, 2, 4, 0,  18,  17,  2};
    tbl[3] = '{0, 0, 3, 3, 0, 0, 0, 0, 1, 225, 143, 15};
    tbl[4] = '{0, 1, 2, 8, 1, 0, 0, 0, 0,  -1,  -1, -1};
    tbl[5] = '{0, 0, 2, 8, 1, 0, 0, 0, 1,  -1,  -1, -1};
    tbl[6] = '{1, 0, 3, 3, 0, 0, 0, 0, 0,   7,   7,  3};
    tbl[7] = '{1, 1, 2, 5, 1, 0, 0, 0, 1,  -1,  -1, -1};
    tbl[8] = '{1, 0, 3, 3, 0, 1, 3, 3, 0,   7,   7,  2};

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while a sweep is in flight
    sel = 0; mode = 0; lat_lo = 3; lat_hi = 3; rnd = 0; stall = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    guard = 0;
    while (act_pc != 50 && guard < 5000) begin @(negedge clk); guard++; end
    chk("midrst_reach50", act_pc, 50);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0;
    reqs = 0;
    repeat (40) begin @(negedge clk); reqs += int'(req0) + int'(req1) + int'(busy0); end
    chk("midrst_quiet", reqs, 0);

    run_vec(tbl[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
